// File: rtl/spi_shift_engine.sv
// SPI data-path shifter: configurable frame length, MSB/LSB-first, split sample/shift strobes.
// Optional receive parity output enabled by defining SPI_SHIFT_PARITY_EN.
module spi_shift_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Len,
    input  logic              LsbFirst,
    input  logic              SampleEn,
    input  logic              ShiftEn,
    input  logic              SerIn,
    output logic              SerOut,
    output logic [DATA_W-1:0] DataOut,
    output logic              Busy,
    output logic              Done
`ifdef SPI_SHIFT_PARITY_EN
    ,
    output logic              RxParity
`endif
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] reg_q, reg_d;
    logic              samp_q, samp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              lsb_q, lsb_d;
`ifdef SPI_SHIFT_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [CNT_W-1:0]  len_eff_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              ins_bit_c;
    logic              ser_msb_c;
    logic [DATA_W-1:0] mask_c;

    // Out-of-range lengths collapse to a full-width frame
    assign len_eff_c = ((Len == '0) || (Len > LEN_MAX)) ? LEN_MAX : Len;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    // Simultaneous strobes bypass the sample flop so the fresh MISO bit is used
    assign ins_bit_c = (SampleEn && ShiftEn) ? SerIn : samp_q;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lsb_d   = lsb_q;
`ifdef SPI_SHIFT_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    reg_d = DataIn;
                end
                if (Start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    len_d   = len_eff_c;
                    lsb_d   = LsbFirst;
`ifdef SPI_SHIFT_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (SampleEn) begin
                    samp_d = SerIn;
                end
                if (ShiftEn) begin
                    if (lsb_q) begin
                        reg_d = reg_q >> 1;
                        for (int i = 0; i < int'(DATA_W); i++) begin
                            if (CNT_W'(i) == (len_q - CNT_W'(1))) begin
                                reg_d[i] = ins_bit_c;
                            end
                        end
                    end else begin
                        reg_d = {reg_q[DATA_W-2:0], ins_bit_c};
                    end
                    cnt_d = cnt_inc_c;
`ifdef SPI_SHIFT_PARITY_EN
                    par_d = par_q ^ ins_bit_c;
`endif
                    if (cnt_inc_c == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            samp_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= LEN_MAX;
            lsb_q   <= 1'b0;
`ifdef SPI_SHIFT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lsb_q   <= lsb_d;
`ifdef SPI_SHIFT_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Top-of-frame bit select and receive mask, both keyed on the latched length
    always_comb begin
        ser_msb_c = 1'b0;
        mask_c    = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (CNT_W'(i) == (len_q - CNT_W'(1))) begin
                ser_msb_c = reg_q[i];
            end
            mask_c[i] = (CNT_W'(i) < len_q);
        end
    end

    assign SerOut  = lsb_q ? reg_q[0] : ser_msb_c;
    assign DataOut = reg_q & mask_c;
    assign Busy    = (state_q != ST_IDLE);
    assign Done    = (state_q == ST_DONE);
`ifdef SPI_SHIFT_PARITY_EN
    assign RxParity = par_q;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: frame-level model plus directed literal checks.
module tb_spi_shift_engine;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic              lsb_first = 1'b0;
    logic              sample_en = 1'b0;
    logic              shift_en = 1'b0;
    logic              ser_in = 1'b0;
    logic              ser_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
`ifdef SPI_SHIFT_PARITY_EN
    logic              rx_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    spi_shift_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Load     (load),
        .DataIn   (data_in),
        .Start    (start),
        .Len      (len),
        .LsbFirst (lsb_first),
        .SampleEn (sample_en),
        .ShiftEn  (shift_en),
        .SerIn    (ser_in),
        .SerOut   (ser_out),
        .DataOut  (data_out),
        .Busy     (busy),
        .Done     (done)
`ifdef SPI_SHIFT_PARITY_EN
        ,
        .RxParity (rx_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: transmit word, received word assembled by bit position
    int                m_phase;   // 0 idle, 1 in frame, 2 frame just ended
    logic [DATA_W-1:0] m_base;    // word visible in idle (loaded or last received)
    logic [DATA_W-1:0] m_tx;
    logic [DATA_W-1:0] m_rx;
    int                m_len;
    int                m_k;
    logic              m_lsb;
    logic              m_samp;
    logic              m_par;

    function automatic logic [DATA_W-1:0] mask_of(input int l);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < l);
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_base = '0; m_tx = '0; m_rx = '0;
            m_len = DATA_W; m_k = 0; m_lsb = 1'b0; m_samp = 1'b0; m_par = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (load) m_base = data_in;
                    if (start) begin
                        m_phase = 1;
                        m_len   = (len == 0 || int'(len) > DATA_W) ? DATA_W : int'(len);
                        m_lsb   = lsb_first;
                        m_tx    = m_base;
                        m_rx    = '0;
                        m_k     = 0;
                        m_par   = 1'b0;
                    end
                end
                1: begin
                    logic b;
                    b = (sample_en && shift_en) ? ser_in : m_samp;
                    if (sample_en) m_samp = ser_in;
                    if (shift_en) begin
                        if (m_lsb) m_rx[m_k] = b;
                        else       m_rx[m_len-1-m_k] = b;
                        m_par = m_par ^ b;
                        m_k++;
                        if (m_k == m_len) begin
                            m_phase = 2;
                            m_base  = m_rx;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_so;
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 2));
            if (m_phase == 1) exp_so = m_lsb ? m_tx[m_k] : m_tx[m_len-1-m_k];
            else              exp_so = m_lsb ? m_base[0] : m_base[m_len-1];
            chk("ser_out", 32'(ser_out), 32'(exp_so));
            if (m_phase != 1) chk("data_out", 32'(data_out), 32'(m_base & mask_of(m_len)));
`ifdef SPI_SHIFT_PARITY_EN
            chk("rx_parity", 32'(rx_parity), 32'(m_par));
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Load, start, then run the frame; records SerOut seen before each shift (bit i = i-th sent)
    task automatic do_frame(input logic [7:0] tx, input logic [CNT_W-1:0] l, input bit lsb,
                            input logic [7:0] rxw, input bit bypass, input int inj,
                            input int abort_at, output logic [7:0] so);
        int n;
        n  = (l == 0 || int'(l) > DATA_W) ? DATA_W : int'(l);
        so = '0;
        load = 1'b1; data_in = tx; step(); load = 1'b0;
        start = 1'b1; len = l; lsb_first = lsb; step(); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic b;
            b = lsb ? rxw[i] : rxw[n-1-i];
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_data", 32'(data_out), 32'd0);
                chk("abort_serout", 32'(ser_out), 32'd0);
                step();
                rst = 1'b0;
                return;
            end
            if (i == inj) begin
                load = 1'b1; data_in = 8'hFF; start = 1'b1; len = 4'd2; lsb_first = !lsb;
                step();
                load = 1'b0; start = 1'b0;
            end
            so[i] = ser_out;
            ser_in = b;
            if (bypass) begin
                sample_en = 1'b1; shift_en = 1'b1; step();
                sample_en = 1'b0; shift_en = 1'b0; ser_in = !b;
            end else begin
                sample_en = 1'b1; step(); sample_en = 1'b0;
                ser_in = !b; shift_en = 1'b1; step(); shift_en = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] so;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_serout", 32'(ser_out), 32'd0);
        rst = 1'b0;
        step();

        // MSB-first full frame
        do_frame(8'hA5, 4'd8, 1'b0, 8'h3C, 1'b0, -1, -1, so);
        chk("t1_seq", 32'(so), 32'hA5);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_data", 32'(data_out), 32'h3C);
`ifdef SPI_SHIFT_PARITY_EN
        chk("t1_par", 32'(rx_parity), 32'd0);
`endif
        step();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_after", 32'(done), 32'd0);

        // LSB-first full frame
        do_frame(8'hA5, 4'd8, 1'b1, 8'h3C, 1'b0, -1, -1, so);
        chk("t2_seq", 32'(so), 32'hA5);
        chk("t2_data", 32'(data_out), 32'h3C);
        step();

        // Short frame, upper bits masked
        do_frame(8'h0B, 4'd4, 1'b0, 8'h06, 1'b0, -1, -1, so);
        chk("t3_seq", 32'(so), 32'h0D);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_data", 32'(data_out), 32'h06);
        step();

        // Len=0 treated as full width
        do_frame(8'h5A, 4'd0, 1'b0, 8'h96, 1'b0, -1, -1, so);
        chk("t4_seq", 32'(so), 32'h5A);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_data", 32'(data_out), 32'h96);
        step();

        // Same-cycle sample and shift uses SerIn directly
        do_frame(8'hA5, 4'd8, 1'b0, 8'hC3, 1'b1, -1, -1, so);
        chk("t5_data", 32'(data_out), 32'hC3);
        step();

        // Load/Start/Len/LsbFirst changes mid-frame are ignored
        do_frame(8'hA5, 4'd8, 1'b0, 8'h3D, 1'b0, 3, -1, so);
        chk("t6_seq", 32'(so), 32'hA5);
        chk("t6_data", 32'(data_out), 32'h3D);
`ifdef SPI_SHIFT_PARITY_EN
        chk("t6_par", 32'(rx_parity), 32'd1);
`endif
        step();

        // Reset after three shifts aborts; next frame completes
        do_frame(8'hA5, 4'd8, 1'b0, 8'h3C, 1'b0, -1, 3, so);
        step();
        chk("t7_idle_busy", 32'(busy), 32'd0);
        do_frame(8'h5A, 4'd8, 1'b1, 8'h69, 1'b0, -1, -1, so);
        chk("t7_seq", 32'(so), 32'h5A);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_data", 32'(data_out), 32'h69);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
